// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path (and the future transmitter).
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_e;

   typedef struct packed {
      logic brk;
      logic overrun;
      logic parity;
      logic framing;
   } rx_err_t;

   // One spare bit so that acc + increment never wraps before the compare.
   function automatic int acc_width(input int clk_rate);
      return $clog2(clk_rate) + 1;
   endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Fractional 16x oversample tick generator: phase accumulator with zero long-term rate error.
module uart_os_tick_gen
   import uart_pkg::*;
#(
   parameter int CLK_RATE  = 100_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic CLK_I,
   input  logic RST_NI,
   input  logic sync_clr,
   output logic os_tick
);

   localparam int           W    = acc_width(CLK_RATE);
   localparam logic [W-1:0] INC  = W'(BAUD_RATE * OVERSAMPLE);
   localparam logic [W-1:0] RATE = W'(CLK_RATE);
   localparam logic [W-1:0] HALF = W'(CLK_RATE / 2);

   logic [W-1:0] acc_q;
   logic [W-1:0] sum;

   assign sum = acc_q + INC;

   // NOTE: flops are written with non-blocking assignments only, so every
   // always_ff reads the pre-edge value of every other flop.
   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         acc_q   <= '0;
         os_tick <= 1'b0;
      end else if (sync_clr) begin
         // Starting half-way phase-aligns the first tick to the detected edge.
         acc_q   <= HALF;
         os_tick <= 1'b0;
      end else if (sum >= RATE) begin
         acc_q   <= sum - RATE;
         os_tick <= 1'b1;
      end else begin
         acc_q   <= sum;
         os_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver, 16x oversampled with 3-sample majority vote.
// Optional parity bit compiled in with UART_RX_PARITY_EN.
module uart_rx_ext
   import uart_pkg::*;
#(
   parameter int CLK_RATE   = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 CLK_I,
   input  logic                 RST_NI,
   input  logic                 RX_I,
   output logic [DATA_BITS-1:0] DATA_O,
   output logic                 VALID_O,
   input  logic                 READY_I,
   output logic [3:0]           ERR_O,
   output logic                 BUSY_O
);

   if (CLK_RATE < 2 * OVERSAMPLE * BAUD_RATE) begin : g_bad_rate
      $error("uart_rx_ext: CLK_RATE must be at least 32x BAUD_RATE");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_rx_ext: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_ext: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
      $error("uart_rx_ext: PARITY_ODD must be 0 or 1");
   end

`ifdef UART_RX_PARITY_EN
   localparam rx_state_e AFTER_DATA = PARITY;
`else
   localparam rx_state_e AFTER_DATA = STOP;
`endif

   logic                 rx_meta, rx_sync, rx_prev, fall;
   logic                 os_tick, sync_clr, commit;
   logic                 tick9, bit_end, last_stop;
   rx_state_e            state_q, state_d;
   logic [3:0]           os_cnt, bit_cnt;
   logic                 stop_cnt;
   logic                 s7_q, s8_q, vote;
   logic [DATA_BITS-1:0] sreg, data_q;
   logic                 fr_q, brk_q, fr_next, brk_next, par_zero, par_err_now;
   logic                 valid_q;
   rx_err_t              err_q, err_new;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit_q, par_err_q;
`endif

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) {rx_meta, rx_sync, rx_prev} <= 3'b111;
      else         {rx_meta, rx_sync, rx_prev} <= {RX_I, rx_meta, rx_sync};
   end

   uart_os_tick_gen #(
      .CLK_RATE (CLK_RATE),
      .BAUD_RATE(BAUD_RATE)
   ) u_tick (
      .CLK_I   (CLK_I),
      .RST_NI  (RST_NI),
      .sync_clr(sync_clr),
      .os_tick (os_tick)
   );

   assign fall      = rx_prev & ~rx_sync;
   assign tick9     = os_tick && (os_cnt == 4'd9);
   assign bit_end   = os_tick && (os_cnt == 4'd15);
   assign last_stop = (STOP_BITS == 1) || stop_cnt;
   assign vote      = (s7_q & s8_q) | (s7_q & rx_sync) | (s8_q & rx_sync);

`ifdef UART_RX_PARITY_EN
   assign par_zero    = ~par_bit_q;
   assign par_err_now = par_err_q;
`else
   assign par_zero    = 1'b1;
   assign par_err_now = 1'b0;
`endif

   // Break is judged on the first stop bit only; framing accumulates over all of them.
   assign fr_next  = fr_q | ~vote;
   assign brk_next = stop_cnt ? brk_q : ((sreg == '0) && par_zero && !vote);
   assign err_new  = '{brk: brk_next, overrun: 1'b0, parity: par_err_now, framing: fr_next};

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      sync_clr = 1'b0;
      commit   = 1'b0;
      case (state_q)
         IDLE: if (fall) begin
            state_d  = START;
            sync_clr = 1'b1;
         end
         START: begin
            if (tick9 && vote) state_d = IDLE;
            else if (bit_end)  state_d = DATA;
         end
         DATA: if (bit_end && (bit_cnt == 4'(DATA_BITS - 1))) state_d = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
         PARITY: if (bit_end) state_d = STOP;
`endif
         STOP: if (tick9 && last_stop) begin
            commit  = 1'b1;
            state_d = (fr_next || brk_next) ? WAIT_IDLE : IDLE;
         end
         WAIT_IDLE: if (rx_sync) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         os_cnt   <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         s7_q     <= 1'b1;
         s8_q     <= 1'b1;
         sreg     <= '0;
         fr_q     <= 1'b0;
         brk_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q <= 1'b0;
         par_err_q <= 1'b0;
`endif
      end else if (sync_clr) begin
         os_cnt   <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         fr_q     <= 1'b0;
         brk_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q <= 1'b0;
         par_err_q <= 1'b0;
`endif
      end else if (os_tick) begin
         os_cnt <= os_cnt + 4'd1;
         if (os_cnt == 4'd7) s7_q <= rx_sync;
         if (os_cnt == 4'd8) s8_q <= rx_sync;
         if (os_cnt == 4'd9) begin
            case (state_q)
               DATA: sreg <= {vote, sreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  par_bit_q <= vote;
                  par_err_q <= ((^sreg) ^ vote) != 1'(PARITY_ODD);
               end
`endif
               STOP: begin
                  fr_q  <= fr_next;
                  brk_q <= brk_next;
               end
               default: ;
            endcase
         end
         if (os_cnt == 4'd15) begin
            if (state_q == DATA) bit_cnt  <= bit_cnt + 4'd1;
            if (state_q == STOP) stop_cnt <= 1'b1;
         end
      end
   end

   // Single-entry output register; a word arriving while one is still held is dropped.
   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         err_q   <= '0;
      end else if (commit) begin
         if (!valid_q || READY_I) begin
            valid_q <= 1'b1;
            data_q  <= sreg;
            err_q   <= err_new;
         end else begin
            err_q.overrun <= 1'b1;
         end
      end else if (valid_q && READY_I) begin
         valid_q <= 1'b0;
      end
   end

   assign DATA_O  = data_q;
   assign VALID_O = valid_q;
   assign ERR_O   = err_q;
   assign BUSY_O  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: frame-level model with an expected-word queue.
// Build with UART_RX_PARITY_EN for the 7E2 parity run, without it for the 8N1 run.
module tb_uart_rx_ext;

`ifdef UART_RX_PARITY_EN
   localparam int DB = 7;
   localparam int SB = 2;
`else
   localparam int DB = 8;
   localparam int SB = 1;
`endif
   localparam int         CLK_RATE   = 100_000_000;
   localparam int         BAUD       = 115200;
   localparam logic       PARITY_ODD = 1'b0;
   localparam real        BIT_T      = 1.0e12 / 115200.0;  // clock period is 10000 units
   localparam logic [8:0] DMASK      = 9'((1 << DB) - 1);

   typedef struct {
      logic [8:0] data;
      logic [3:0] err;
   } word_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx;
   logic          ready;
   logic [DB-1:0] data;
   logic          valid;
   logic [3:0]    err;
   logic          busy;

   word_t         exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            words_seen = 0;
   logic [8:0]    last_data;
   logic [3:0]    last_err;
   logic          valid_d = 1'b0;
   logic [DB-1:0] hold_data;
   logic [3:0]    hold_err;

   uart_rx_ext #(
      .CLK_RATE  (CLK_RATE),
      .BAUD_RATE (BAUD),
      .DATA_BITS (DB),
      .STOP_BITS (SB),
      .PARITY_ODD(0)
   ) dut (
      .CLK_I  (clk),
      .RST_NI (rst_n),
      .RX_I   (rx),
      .DATA_O (data),
      .VALID_O(valid),
      .READY_I(ready),
      .ERR_O  (err),
      .BUSY_O (busy)
   );

   initial forever #5000 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected word from the frame as sent on the line; overrun marks the held word.
   task automatic model_commit(input logic [8:0] d, input logic par, input logic [1:0] stop);
      word_t      w;
      word_t      h;
      logic [8:0] dm;
      dm      = d & DMASK;
      w.data  = dm;
      w.err   = 4'b0000;
      w.err[0] = !stop[0] || (SB == 2 && !stop[1]);
`ifdef UART_RX_PARITY_EN
      w.err[1] = ((^dm) ^ par) != PARITY_ODD;
      w.err[3] = (dm == 9'd0) && !par && !stop[0];
`else
      w.err[3] = (dm == 9'd0) && !stop[0] && !par;
`endif
      if (!ready && exp_q.size() > 0) begin
         h = exp_q[exp_q.size() - 1];
         h.err[2] = 1'b1;
         exp_q[exp_q.size() - 1] = h;
      end else begin
         exp_q.push_back(w);
      end
   endtask

   task automatic send_frame(input logic [8:0] d, input logic par, input logic [1:0] stop,
                             input real bit_t);
      model_commit(d, par, stop);
      rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < DB; i++) begin
         rx = d[i];
         #(bit_t);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      #(bit_t);
`endif
      for (int i = 0; i < SB; i++) begin
         rx = stop[i];
         #(bit_t);
      end
      rx = 1'b1;
   endtask

   task automatic wait_words(input int n);
      for (int i = 0; i < 4000 && words_seen < n; i++) @(posedge clk);
      check("word_count", words_seen, n);
   endtask

   // Compare process: every accepted word against the model, held word stability.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid && valid_d) begin
            check("data_stable", data, hold_data);
            check("err_stable", err & 4'b1011, hold_err & 4'b1011);
         end
         if (valid && ready) begin
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               check("word_data", data, exp_q[0].data);
               check("word_err", err, exp_q[0].err);
               void'(exp_q.pop_front());
            end
            last_data = 9'(data);
            last_err  = err;
            words_seen++;
         end
         valid_d   = valid;
         hold_data = data;
         hold_err  = err;
      end else begin
         valid_d = 1'b0;
      end
   end

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(posedge clk);

      // Reset in the middle of a frame must abort it without a word.
      rx = 1'b0;
      #(BIT_T * 1.5);
      check("midframe_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midframe_rst_busy", busy, 0);
      check("midframe_rst_valid", valid, 0);
      rx = 1'b1;
      #(BIT_T);
      @(negedge clk) rst_n = 1'b1;
      #(BIT_T * 0.5);

`ifdef UART_RX_PARITY_EN
      send_frame(9'h041, 1'b1, 2'b11, BIT_T);
      wait_words(1);
      check("par_bad_data", last_data, 9'h041);
      check("par_bad_err", last_err, 4'b0010);
      #(BIT_T);
      send_frame(9'h041, 1'b0, 2'b11, BIT_T / 1.02);
      wait_words(2);
      check("par_fast_data", last_data, 9'h041);
      check("par_fast_err", last_err, 4'b0000);
      #(BIT_T);
`else
      send_frame(9'h0A5, 1'b0, 2'b11, BIT_T);
      wait_words(1);
      check("a5_data", last_data, 9'h0A5);
      check("a5_err", last_err, 4'b0000);
      #(BIT_T * 0.5);

      // Half-bit glitch: the START vote sees a high line and gives up.
      rx = 1'b0;
      #(BIT_T * 0.5);
      rx = 1'b1;
      for (int i = 0; i < 900 && busy; i++) @(posedge clk);
      #1;
      check("glitch_busy_clear", busy, 0);
      check("glitch_no_word", words_seen, 1);
      #(BIT_T * 0.5);

      send_frame(9'h03C, 1'b0, 2'b00, BIT_T);
      wait_words(2);
      check("3c_data", last_data, 9'h03C);
      check("3c_err", last_err, 4'b0001);
      #(BIT_T);
      send_frame(9'h055, 1'b0, 2'b11, BIT_T);
      wait_words(3);
      check("55_data", last_data, 9'h055);
      check("55_err", last_err, 4'b0000);
      #(BIT_T * 0.5);

      // 30 bit times of low line yields exactly one break word.
      model_commit(9'h000, 1'b0, 2'b00);
      rx = 1'b0;
      #(BIT_T * 30.0);
      rx = 1'b1;
      wait_words(4);
      check("brk_data", last_data, 9'h000);
      check("brk_err", last_err, 4'b1001);
      #(BIT_T);

      ready = 1'b0;
      send_frame(9'h011, 1'b0, 2'b11, BIT_T);
      #(BIT_T * 0.5);
      send_frame(9'h022, 1'b0, 2'b11, BIT_T);
      #(BIT_T * 0.5);
      check("ovr_valid", valid, 1);
      check("ovr_data", data, 8'h11);
      check("ovr_err", err, 4'b0100);
      @(posedge clk);
      #1 ready = 1'b1;
      @(posedge clk);
      #1 ready = 1'b0;
      check("ovr_valid_clear", valid, 0);
      wait_words(5);
      check("ovr_last_data", last_data, 9'h011);
      ready = 1'b1;
      #(BIT_T * 0.5);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
